// File: rtl/id_stage.sv
// Decode/issue stage: register file, write scoreboard and ex_* pipeline register, 1-cycle latency.
// Stalls (in_ready=0) on flush, busy-operand hazard, or a held instruction execute has not taken.
module id_stage (
   input  logic       clock,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [4:0] opcode,
   input  logic [2:0] register_a,
   input  logic [2:0] register_b,
   input  logic [3:0] immidiate_data1,
   input  logic [3:0] immidiate_data2,
   input  logic       mux_select,
   input  logic       flush,
   input  logic       wb_en,
   input  logic [2:0] wb_addr,
   input  logic [7:0] wb_data,
   output logic       ex_valid,
   input  logic       ex_ready,
   output logic [4:0] ex_opcode,
   output logic [2:0] ex_dest,
   output logic [7:0] ex_operand_a,
   output logic [7:0] ex_operand_b,
   output logic       ex_write_en
);

   logic [7:0] regs [8];
   logic [7:0] busy;
   logic [7:0] busy_nxt;
   logic [7:0] wb_mask;
   logic [7:0] eff_busy;
   logic [7:0] rd_a;
   logic [7:0] rd_b;
   logic [7:0] operand_b;
   logic       wb_hit;
   logic       hazard;
   logic       accept;
   logic       writes_dest;

   assign wb_hit      = wb_en && (wb_addr != 3'd0);
   assign wb_mask     = wb_en ? (8'd1 << wb_addr) : 8'd0;
   // A register being written back this cycle is no longer a hazard.
   assign eff_busy    = busy & ~wb_mask;
   assign hazard      = eff_busy[register_a] | (~mux_select & eff_busy[register_b]);
   assign in_ready    = ~flush & ~hazard & (~ex_valid | ex_ready);
   assign accept      = in_valid & in_ready;
   assign writes_dest = (opcode != 5'd0) && !opcode[4];
   assign operand_b   = mux_select ? {immidiate_data1, immidiate_data2} : rd_b;

   always_comb begin
      rd_a = regs[register_a];
      if (register_a == 3'd0)
         rd_a = 8'd0;
      else if (wb_hit && (wb_addr == register_a))
         rd_a = wb_data;
   end

   always_comb begin
      rd_b = regs[register_b];
      if (register_b == 3'd0)
         rd_b = 8'd0;
      else if (wb_hit && (wb_addr == register_b))
         rd_b = wb_data;
   end

   // Issue set beats writeback clear on the same register; flush beats both.
   always_comb begin
      busy_nxt = busy & ~wb_mask;
      if (accept && writes_dest && (register_a != 3'd0))
         busy_nxt[register_a] = 1'b1;
      if (flush)
         busy_nxt = 8'd0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++)
            regs[i] <= 8'd0;
         busy         <= 8'd0;
         ex_valid     <= 1'b0;
         ex_opcode    <= 5'd0;
         ex_dest      <= 3'd0;
         ex_operand_a <= 8'd0;
         ex_operand_b <= 8'd0;
         ex_write_en  <= 1'b0;
      end else begin
         if (wb_hit)
            regs[wb_addr] <= wb_data;
         busy <= busy_nxt;
         if (flush)
            ex_valid <= 1'b0;
         else if (accept)
            ex_valid <= 1'b1;
         else if (ex_ready)
            ex_valid <= 1'b0;
         if (accept) begin
            ex_opcode    <= opcode;
            ex_dest      <= register_a;
            ex_operand_a <= rd_a;
            ex_operand_b <= operand_b;
            ex_write_en  <= writes_dest;
         end
      end
   end

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, back-to-back issue sequence, then random traffic
// checked against a per-cycle behavioural model of registers, busy flags and the ex slot.
module tb_id_stage;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [4:0] opcode;
   logic [2:0] register_a;
   logic [2:0] register_b;
   logic [3:0] immidiate_data1;
   logic [3:0] immidiate_data2;
   logic       mux_select;
   logic       flush;
   logic       wb_en;
   logic [2:0] wb_addr;
   logic [7:0] wb_data;
   logic       ex_valid;
   logic       ex_ready;
   logic [4:0] ex_opcode;
   logic [2:0] ex_dest;
   logic [7:0] ex_operand_a;
   logic [7:0] ex_operand_b;
   logic       ex_write_en;

   id_stage dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .register_a(register_a), .register_b(register_b),
      .immidiate_data1(immidiate_data1), .immidiate_data2(immidiate_data2),
      .mux_select(mux_select), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_opcode(ex_opcode), .ex_dest(ex_dest), .ex_operand_a(ex_operand_a),
      .ex_operand_b(ex_operand_b), .ex_write_en(ex_write_en)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit         rst, iv;
      logic [4:0] op;
      logic [2:0] ra, rb;
      logic [7:0] imm;
      bit         ms, fl, we;
      logic [2:0] wa;
      logic [7:0] wd;
      bit         er;
      bit         ck_rdy, rdy, ck_dat, vld;
      logic [4:0] eop;
      logic [2:0] edst;
      logic [7:0] ea, eb;
      bit         ewe;
   } vec_t;

   vec_t tab[$];
   int   total = 0;
   int   bad   = 0;

   // Behavioural model state
   logic [7:0] m_reg [8];
   bit         m_busy [8];
   bit         m_vld, m_we;
   logic [4:0] m_op;
   logic [2:0] m_dst;
   logic [7:0] m_a, m_b;

   function automatic void row(bit rst, bit iv, logic [4:0] op, logic [2:0] ra, logic [2:0] rb,
                               logic [7:0] imm, bit ms, bit fl, bit we, logic [2:0] wa,
                               logic [7:0] wd, bit er, bit ck_rdy, bit rdy, bit ck_dat, bit vld,
                               logic [4:0] eop, logic [2:0] edst, logic [7:0] ea, logic [7:0] eb,
                               bit ewe);
      vec_t v;
      v.rst = rst; v.iv = iv; v.op = op; v.ra = ra; v.rb = rb; v.imm = imm; v.ms = ms;
      v.fl = fl; v.we = we; v.wa = wa; v.wd = wd; v.er = er; v.ck_rdy = ck_rdy; v.rdy = rdy;
      v.ck_dat = ck_dat; v.vld = vld; v.eop = eop; v.edst = edst; v.ea = ea; v.eb = eb;
      v.ewe = ewe;
      tab.push_back(v);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] m_rd(input logic [2:0] idx);
      if (idx == 0) return 8'd0;
      if (wb_en && wb_addr == idx) return wb_data;
      return m_reg[idx];
   endfunction

   function automatic bit m_pending(input logic [2:0] idx);
      return m_busy[idx] && !(wb_en && wb_addr == idx);
   endfunction

   function automatic bit m_ready();
      bit stall;
      stall = m_pending(register_a) || (!mux_select && m_pending(register_b));
      return !flush && !stall && (!m_vld || ex_ready);
   endfunction

   function automatic void m_update();
      bit acc, wd;
      if (reset) begin
         for (int i = 0; i < 8; i++) begin m_reg[i] = 0; m_busy[i] = 0; end
         m_vld = 0; m_we = 0; m_op = 0; m_dst = 0; m_a = 0; m_b = 0;
         return;
      end
      acc = in_valid && m_ready();
      wd  = (opcode != 0) && (opcode < 16);
      if (acc) begin
         m_op  = opcode;
         m_dst = register_a;
         m_a   = m_rd(register_a);
         m_b   = mux_select ? {immidiate_data1, immidiate_data2} : m_rd(register_b);
         m_we  = wd;
      end
      if (flush)          m_vld = 0;
      else if (acc)       m_vld = 1;
      else if (ex_ready)  m_vld = 0;
      if (wb_en) m_busy[wb_addr] = 0;
      if (acc && wd && register_a != 0) m_busy[register_a] = 1;
      if (flush) for (int i = 0; i < 8; i++) m_busy[i] = 0;
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
   endfunction

   // One clock: drive at the falling edge, check in_ready mid-phase, check ex_* after the edge.
   task automatic step(input vec_t v, input bit use_tab);
      bit exp_rdy;
      reset = v.rst; in_valid = v.iv; opcode = v.op; register_a = v.ra; register_b = v.rb;
      immidiate_data1 = v.imm[7:4]; immidiate_data2 = v.imm[3:0]; mux_select = v.ms;
      flush = v.fl; wb_en = v.we; wb_addr = v.wa; wb_data = v.wd; ex_ready = v.er;
      #1;
      exp_rdy = use_tab ? v.rdy : m_ready();
      if (!v.rst && (!use_tab || v.ck_rdy)) chk("in_ready", in_ready, exp_rdy);
      m_update();
      @(posedge clock);
      #1;
      if (use_tab) begin
         chk("ex_valid", ex_valid, v.vld);
         if (v.ck_dat) begin
            chk("ex_opcode", ex_opcode, v.eop);
            chk("ex_dest", ex_dest, v.edst);
            chk("ex_operand_a", ex_operand_a, v.ea);
            chk("ex_operand_b", ex_operand_b, v.eb);
            chk("ex_write_en", ex_write_en, v.ewe);
         end
      end else begin
         chk("ex_valid_model", ex_valid, m_vld);
         if (m_vld) begin
            chk("ex_opcode_model", ex_opcode, m_op);
            chk("ex_dest_model", ex_dest, m_dst);
            chk("ex_operand_a_model", ex_operand_a, m_a);
            chk("ex_operand_b_model", ex_operand_b, m_b);
            chk("ex_write_en_model", ex_write_en, m_we);
         end
      end
      @(negedge clock);
   endtask

   initial begin
      vec_t v;
      // rst iv op  ra rb imm  ms fl we wa wd  er | crdy rdy cdat vld eop edst ea  eb  ewe
      row(1,0,0,    0,0,8'h00,0,0,0,0,8'h00,0,  0,0, 1,0,5'h00,0,8'h00,8'h00,0); // reset state
      row(0,0,0,    0,0,8'h00,0,0,1,3,8'h5A,0,  1,1, 1,0,5'h00,0,8'h00,8'h00,0);
      row(0,1,1,    3,0,8'h42,1,0,0,0,8'h00,0,  1,1, 1,1,5'h01,3,8'h5A,8'h42,1);
      row(0,0,0,    0,0,8'h00,0,0,0,0,8'h00,1,  1,1, 0,0,5'h00,0,8'h00,8'h00,0);
      row(0,0,0,    0,0,8'h00,0,0,1,3,8'h77,1,  1,1, 0,0,5'h00,0,8'h00,8'h00,0);
      row(0,1,1,    2,0,8'h00,1,0,0,0,8'h00,1,  1,1, 1,1,5'h01,2,8'h00,8'h00,1);
      row(0,1,1,    2,3,8'h00,0,0,0,0,8'h00,1,  1,0, 0,0,5'h00,0,8'h00,8'h00,0); // RAW stall
      row(0,1,1,    2,3,8'h00,0,0,0,0,8'h00,1,  1,0, 0,0,5'h00,0,8'h00,8'h00,0);
      row(0,1,1,    2,3,8'h00,0,0,1,2,8'h11,1,  1,1, 1,1,5'h01,2,8'h11,8'h77,1); // wb bypass
      row(0,1,1,    2,3,8'h00,0,0,0,0,8'h00,1,  1,0, 0,0,5'h00,0,8'h00,8'h00,0); // set won
      row(0,0,0,    0,0,8'h00,0,0,1,2,8'h22,1,  1,1, 0,0,5'h00,0,8'h00,8'h00,0);
      row(0,1,3,    1,2,8'h00,0,0,0,0,8'h00,0,  1,1, 1,1,5'h03,1,8'h00,8'h22,1);
      for (int k = 0; k < 3; k++)                                                       // backpressure
         row(0,1,5, 4,3,8'h00,0,0,0,0,8'h00,0,  1,0, 1,1,5'h03,1,8'h00,8'h22,1);
      row(0,1,5,    4,3,8'h00,0,0,0,0,8'h00,1,  1,1, 1,1,5'h05,4,8'h00,8'h77,1);
      row(0,1,1,    0,0,8'h00,1,1,1,5,8'h33,0,  1,0, 0,0,5'h00,0,8'h00,8'h00,0); // flush + wb
      row(0,1,5'h10,6,5,8'h00,0,0,0,0,8'h00,0,  1,1, 1,1,5'h10,6,8'h00,8'h33,0);
      row(0,1,1,    4,6,8'h00,0,0,0,0,8'h00,1,  1,1, 1,1,5'h01,4,8'h00,8'h00,1);
      row(0,1,1,    7,1,8'h00,0,0,0,0,8'h00,1,  1,1, 1,1,5'h01,7,8'h00,8'h00,1);
      row(0,1,2,    0,0,8'h00,0,0,1,0,8'hFF,1,  1,1, 1,1,5'h02,0,8'h00,8'h00,1); // R0 write
      row(0,1,2,    0,0,8'h00,0,0,0,0,8'h00,1,  1,1, 1,1,5'h02,0,8'h00,8'h00,1);
      row(0,1,4,    5,5,8'h00,0,0,1,5,8'hC3,1,  1,1, 1,1,5'h04,5,8'hC3,8'hC3,1);
      row(0,1,1,    5,0,8'h00,1,0,0,0,8'h00,1,  1,0, 0,0,5'h00,0,8'h00,8'h00,0);
      row(1,1,1,    5,0,8'h00,1,1,1,1,8'h99,1,  0,0, 1,0,5'h00,0,8'h00,8'h00,0); // reset mid-stall
      row(0,1,1,    5,1,8'h00,0,0,0,0,8'h00,0,  1,1, 1,1,5'h01,5,8'h00,8'h00,1);

      reset = 1'b1; in_valid = 0; opcode = 0; register_a = 0; register_b = 0;
      immidiate_data1 = 0; immidiate_data2 = 0; mux_select = 0; flush = 0;
      wb_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 0;
      @(negedge clock);

      foreach (tab[i]) step(tab[i], 1'b1);

      // Back-to-back independent immediates with execute always ready
      v = tab[0];
      v.rst = 0; v.iv = 1; v.op = 1; v.ms = 1; v.er = 1; v.we = 0; v.fl = 0; v.rb = 0;
      for (int k = 0; k < 4; k++) begin
         v.ra  = 3'(k + 1);
         v.imm = 8'(k * 8'h11 + 1);
         step(v, 1'b0);
      end

      // Randomised traffic against the model, starting from a fresh reset
      v.rst = 1; v.iv = 0; v.we = 0; v.fl = 0;
      step(v, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         v.rst = ($urandom_range(0, 299) == 0);
         v.iv  = ($urandom_range(0, 3) != 0);
         v.op  = 5'($urandom);
         v.ra  = 3'($urandom);
         v.rb  = 3'($urandom);
         v.imm = 8'($urandom);
         v.ms  = $urandom_range(0, 1);
         v.fl  = ($urandom_range(0, 24) == 0);
         v.we  = ($urandom_range(0, 2) == 0);
         v.wa  = 3'($urandom);
         v.wd  = 8'($urandom);
         v.er  = ($urandom_range(0, 2) != 0);
         step(v, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 clock  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; sampled on clock rising edge.
REQ-003 in_valid  in  1  decoded fields from the id_ir register are valid.
REQ-004 in_ready  out  1  id_stage accepts the fields this cycle.
REQ-005 opcode  in  5  operation; writes_dest = (opcode != 0) && (opcode[4] == 0).
REQ-006 register_a  in  3  destination and source-A register index.
REQ-007 register_b  in  3  source-B register index.
REQ-008 immidiate_data1 / immidiate_data2  in  4 each  immediate = {immidiate_data1, immidiate_data2}, 8 bits.
REQ-009 mux_select  in  1  1 = operand B is the immediate; 0 = operand B is R[register_b].
REQ-010 flush  in  1  discard held instruction and clear scoreboard.
REQ-011 wb_en / wb_addr / wb_data  in  1/3/8  register-file write port from writeback.
REQ-012 ex_valid  out  1  ex_* outputs hold a valid instruction.
REQ-013 ex_ready  in  1  execute stage takes the held instruction this cycle.
REQ-014 ex_opcode / ex_dest  out  5/3  registered opcode and destination index.
REQ-015 ex_operand_a / ex_operand_b  out  8 each  registered operands.
REQ-016 ex_write_en  out  1  registered writes_dest.

Function
REQ-017 Register file SHALL hold 8 x 8-bit entries; R0 reads 0, writes to R0 ignored.
REQ-018 wb_en with wb_addr != 0 SHALL write wb_data at the clock edge, including during flush.
REQ-019 Reads SHALL be write-through: source index == wb_addr with wb_en (addr != 0) returns wb_data same cycle.
REQ-020 Scoreboard busy[7:0] SHALL mark registers with an issued, unretired write; busy[0] is always 0.
REQ-021 Effective busy eb[i] SHALL be busy[i] & ~(wb_en & wb_addr == i).
REQ-022 hazard SHALL be eb[register_a] | (~mux_select & eb[register_b]).
REQ-023 in_ready SHALL be ~flush & ~hazard & (~ex_valid | ex_ready), combinational.
REQ-024 accept = in_valid & in_ready; on accept the ex_* registers SHALL load next edge: opcode, register_a, R[register_a], (mux_select ? immediate : R[register_b]), writes_dest; ex_valid <= 1.
REQ-025 Latency: accepted fields SHALL appear on ex_* exactly 1 cycle later.
REQ-026 ex_valid & ~ex_ready SHALL hold all ex_* outputs stable (no accept possible).
REQ-027 ex_valid & ex_ready & ~accept SHALL clear ex_valid next edge; ex_* data may hold.
REQ-028 Accept with writes_dest and register_a != 0 SHALL set busy[register_a]; wb_en clears busy[wb_addr]; same-register set and clear in one cycle: set wins.
REQ-029 flush SHALL, at next edge, clear ex_valid and all busy bits, overriding any set; downstream stages drop in-flight instructions on the same flush.
REQ-030 Operand arithmetic none; all values are raw 8-bit, no sign extension of immediate.

Reset
REQ-031 reset SHALL clear all 8 registers, busy, ex_valid, ex_opcode, ex_dest, ex_operand_a/b, ex_write_en to 0, overriding flush, accept and wb_en.
REQ-032 During reset cycle in_ready SHALL be don't-care; first accept possible on the cycle after reset deasserts.

Verification
REQ-033 After reset: wb_en=1 wb_addr=3 wb_data=0x5A, next cycle in_valid opcode=1 register_a=3 mux_select=1 imm=0x4,0x2 -> ex_operand_a=0x5A, ex_operand_b=0x42, ex_write_en=1, ex_valid=1 one cycle later.
REQ-034 Issue opcode=1 dest R2, then opcode=1 reading R2 with ex_ready=1 -> in_ready=0 until wb_en wb_addr=2 wb_data=0x11; in that same cycle in_ready=1 and ex_operand_a=0x11 next cycle.
REQ-035 ex_valid=1, ex_ready=0 for 3 cycles, in_valid=1 -> ex_* unchanged, in_ready=0; ex_ready=1 -> new instruction loads next edge.
REQ-036 busy[4]=1, flush=1 with wb_en wb_addr=5 wb_data=0x33 -> ex_valid=0, busy=0, R5=0x33 next cycle; in_ready=0 during flush.
REQ-037 wb_en wb_addr=0 wb_data=0xFF, then read R0 -> operand 0x00; opcode=1 register_a=0 -> busy stays 0, no stall on R0.
REQ-038 Opcode 0x10 (writes_dest=0) to R6 -> ex_write_en=0, busy[6] stays 0; reset mid-stall -> all outputs 0 next cycle.
